// File: rtl/iterative_muldiv.sv
// Iterative multiply/divide unit for the execute stage.
// Multiply: shift-add over a 2*WIDTH accumulator, one multiplier bit per cycle.
// Divide:   restoring shift-subtract, one quotient bit per cycle.
// Signed ops run on magnitudes; signs are re-applied in FIX.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; operands and op latched on the accepting edge
// PREP  | take operand magnitudes, record result/remainder signs
// ITER  | WIDTH iterations of shift-add or shift-subtract
// FIX   | sign correction, divide-by-zero override, write output registers
module iterative_muldiv #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic             flush,
   input  logic [WIDTH-1:0] operand1,
   input  logic [WIDTH-1:0] operand2,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] result_hi,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] PREP = 2'd1;
   localparam logic [1:0] ITER = 2'd2;
   localparam logic [1:0] FIX  = 2'd3;

   logic [1:0]         state;
   logic [CW-1:0]      cnt;
   logic [1:0]         op_q;
   logic [WIDTH-1:0]   opa_q;
   logic [WIDTH-1:0]   opb_q;
   logic [WIDTH-1:0]   mag_b;
   // Multiply: {high, low} partial product. Divide: {remainder, quotient/dividend}.
   logic [2*WIDTH-1:0] acc;
   logic               neg_lo;
   logic               neg_hi;

   logic               is_signed;
   logic               is_div;
   logic [WIDTH-1:0]   abs_a;
   logic [WIDTH-1:0]   abs_b;
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_next;
   logic [WIDTH:0]     div_shift;
   logic [WIDTH:0]     div_diff;
   logic [2*WIDTH-1:0] div_next;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix;
   logic [WIDTH-1:0]   rem_fix;
   logic               accept;

   assign is_signed = op_q[0];
   assign is_div    = op_q[1];
   assign accept    = (state == IDLE) & start & ~flush;

   // Busy covers the request cycle so the hazard unit stalls immediately.
   assign busy = (state != IDLE) | accept;

   // Operand magnitudes and one iteration step of each datapath.
   always_comb begin
      abs_a = (is_signed & opa_q[WIDTH-1]) ? -opa_q : opa_q;
      abs_b = (is_signed & opb_q[WIDTH-1]) ? -opb_q : opb_q;

      mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]}
               + (acc[0] ? {1'b0, mag_b} : {(WIDTH+1){1'b0}});
      mul_next = {mul_sum, acc[WIDTH-1:1]};

      // Remainder stays below the divisor, so the non-subtract path fits WIDTH bits.
      div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
      div_diff  = div_shift - {1'b0, mag_b};
      if (div_diff[WIDTH])
         div_next = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      else
         div_next = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

      prod_fix = neg_lo ? -acc : acc;
      quo_fix  = neg_lo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      rem_fix  = neg_hi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
   end

   // Sequencer and datapath registers; flush overrides every state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         cnt    <= '0;
         op_q   <= '0;
         opa_q  <= '0;
         opb_q  <= '0;
         mag_b  <= '0;
         acc    <= '0;
         neg_lo <= 1'b0;
         neg_hi <= 1'b0;
      end else if (flush) begin
         state <= IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  op_q  <= op;
                  opa_q <= operand1;
                  opb_q <= operand2;
                  state <= PREP;
               end
            end
            PREP: begin
               // Both datapaths start from {zero, magnitude of operand1}.
               mag_b  <= abs_b;
               acc    <= {{WIDTH{1'b0}}, abs_a};
               neg_lo <= is_signed & (opa_q[WIDTH-1] ^ opb_q[WIDTH-1]);
               neg_hi <= is_signed & is_div & opa_q[WIDTH-1];
               cnt    <= '0;
               state  <= ITER;
            end
            ITER: begin
               acc <= is_div ? div_next : mul_next;
               if (cnt == CNT_LAST)
                  state <= FIX;
               else
                  cnt <= cnt + 1'b1;
            end
            FIX: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Output registers load only on a FIX that is not being flushed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result      <= '0;
         result_hi   <= '0;
         div_by_zero <= 1'b0;
         done        <= 1'b0;
      end else begin
         done <= (state == FIX) & ~flush;
         if ((state == FIX) && !flush) begin
            if (!is_div) begin
               result      <= prod_fix[WIDTH-1:0];
               result_hi   <= prod_fix[2*WIDTH-1:WIDTH];
               div_by_zero <= 1'b0;
            end else if (opb_q == '0) begin
               result      <= '1;
               result_hi   <= opa_q;
               div_by_zero <= 1'b1;
            end else begin
               result      <= quo_fix;
               result_hi   <= rem_fix;
               div_by_zero <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_iterative_muldiv.sv
// Directed bench for iterative_muldiv at WIDTH=32 and WIDTH=8.
module tb_iterative_muldiv;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start32, flush32;
   logic [1:0]  op32;
   logic [31:0] a32, b32, res32, hi32;
   logic        busy32, done32, dbz32;
   logic        start8, flush8;
   logic [1:0]  op8;
   logic [7:0]  a8, b8, res8, hi8;
   logic        busy8, done8, dbz8;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   iterative_muldiv #(.WIDTH(32)) dut32 (
      .clk(clk), .rst_n(rst_n), .start(start32), .op(op32), .flush(flush32),
      .operand1(a32), .operand2(b32), .result(res32), .result_hi(hi32),
      .busy(busy32), .done(done32), .div_by_zero(dbz32)
   );

   iterative_muldiv #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .op(op8), .flush(flush8),
      .operand1(a8), .operand2(b8), .result(res8), .result_hi(hi8),
      .busy(busy8), .done(done8), .div_by_zero(dbz8)
   );

   // Called just after a rising edge: raises start in cycle 0, scrambles inputs
   // afterwards, returns the cycle where done is seen (-1 on timeout).
   task automatic run32(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int busy_bad, output logic busy_done);
      lat = -1; busy_bad = 0; busy_done = 1'b1;
      op32 = o; a32 = a; b32 = b; start32 = 1'b1;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if (done32 && c > 0) begin
            lat = c; busy_done = busy32;
            break;
         end
         if (!busy32) busy_bad++;
         @(posedge clk); #1;
         start32 = 1'b0; a32 = $urandom; b32 = $urandom; op32 = ~o;
      end
   endtask

   task automatic run8(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b,
                       output int lat);
      lat = -1;
      @(posedge clk); #1;
      op8 = o; a8 = a; b8 = b; start8 = 1'b1;
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         if (done8 && c > 0) begin
            lat = c;
            break;
         end
         @(posedge clk); #1;
         start8 = 1'b0; a8 = 8'h5A; b8 = 8'hA5; op8 = ~o;
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (res32 !== 32'h0) begin errors++; $display("FAIL reset_result: got %h expected 00000000", res32); end
      checks++; if (hi32 !== 32'h0) begin errors++; $display("FAIL reset_result_hi: got %h expected 00000000", hi32); end
      checks++; if ({busy32, done32, dbz32} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {busy32, done32, dbz32}); end
      rst_n = 1'b1;
   endtask

   task automatic test_mulu;
      int lat, bb; logic bd;
      @(posedge clk); #1;
      run32(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bb, bd);
      checks++; if (lat !== 35) begin errors++; $display("FAIL mulu_latency: got %0d expected 35", lat); end
      checks++; if (bb !== 0) begin errors++; $display("FAIL mulu_busy_low_cycles: got %0d expected 0", bb); end
      checks++; if (bd !== 1'b0) begin errors++; $display("FAIL mulu_busy_at_done: got %b expected 0", bd); end
      checks++; if (hi32 !== 32'hFFFFFFFE) begin errors++; $display("FAIL mulu_hi: got %h expected fffffffe", hi32); end
      checks++; if (res32 !== 32'h00000001) begin errors++; $display("FAIL mulu_lo: got %h expected 00000001", res32); end
      @(posedge clk); #1;
      run32(2'b00, 32'h12345678, 32'h00000010, lat, bb, bd);
      checks++; if ({hi32, res32} !== 64'h00000001_23456780) begin errors++; $display("FAIL mulu_shift: got %h expected 0000000123456780", {hi32, res32}); end
   endtask

   task automatic test_divs;
      int lat, bb; logic bd;
      @(posedge clk); #1;
      run32(2'b11, 32'hFFFFFFF9, 32'd2, lat, bb, bd);
      checks++; if (res32 !== 32'hFFFFFFFD) begin errors++; $display("FAIL divs_neg_quot: got %h expected fffffffd", res32); end
      checks++; if (hi32 !== 32'hFFFFFFFF) begin errors++; $display("FAIL divs_neg_rem: got %h expected ffffffff", hi32); end
      @(posedge clk); #1;
      run32(2'b11, 32'd7, 32'hFFFFFFFE, lat, bb, bd);
      checks++; if ({res32, hi32} !== {32'hFFFFFFFD, 32'd1}) begin errors++; $display("FAIL divs_neg_divisor: got %h_%h expected fffffffd_00000001", res32, hi32); end
      @(posedge clk); #1;
      run32(2'b10, 32'd100, 32'd7, lat, bb, bd);
      checks++; if ({res32, hi32} !== {32'd14, 32'd2}) begin errors++; $display("FAIL divu_basic: got %h_%h expected 0000000e_00000002", res32, hi32); end
      checks++; if (dbz32 !== 1'b0) begin errors++; $display("FAIL divu_dbz_clear: got %b expected 0", dbz32); end
   endtask

   task automatic test_div_by_zero;
      int lat, bb; logic bd;
      @(posedge clk); #1;
      run32(2'b10, 32'd100, 32'd0, lat, bb, bd);
      checks++; if (lat !== 35) begin errors++; $display("FAIL dbz_latency: got %0d expected 35", lat); end
      checks++; if (res32 !== 32'hFFFFFFFF) begin errors++; $display("FAIL dbz_result: got %h expected ffffffff", res32); end
      checks++; if (hi32 !== 32'd100) begin errors++; $display("FAIL dbz_result_hi: got %h expected 00000064", hi32); end
      checks++; if (dbz32 !== 1'b1) begin errors++; $display("FAIL dbz_flag: got %b expected 1", dbz32); end
      @(posedge clk); #1;
      run32(2'b11, 32'h80000000, 32'd0, lat, bb, bd);
      checks++; if ({res32, hi32, dbz32} !== {32'hFFFFFFFF, 32'h80000000, 1'b1}) begin errors++; $display("FAIL dbz_signed: got %h_%h_%b expected ffffffff_80000000_1", res32, hi32, dbz32); end
   endtask

   task automatic test_muls;
      int lat, bb; logic bd;
      @(posedge clk); #1;
      run32(2'b01, 32'hFFFFFFFD, 32'd7, lat, bb, bd);
      checks++; if (hi32 !== 32'hFFFFFFFF) begin errors++; $display("FAIL muls_hi: got %h expected ffffffff", hi32); end
      checks++; if (res32 !== 32'hFFFFFFEB) begin errors++; $display("FAIL muls_lo: got %h expected ffffffeb", res32); end
      checks++; if (dbz32 !== 1'b0) begin errors++; $display("FAIL muls_dbz_clear: got %b expected 0", dbz32); end
      @(posedge clk); #1;
      run32(2'b01, 32'hFFFFFFFB, 32'hFFFFFFFA, lat, bb, bd);
      checks++; if ({hi32, res32} !== 64'h0000001E) begin errors++; $display("FAIL muls_both_neg: got %h expected 000000000000001e", {hi32, res32}); end
   endtask

   task automatic test_width8;
      int lat;
      run8(2'b11, 8'h80, 8'hFF, lat);
      checks++; if (lat !== 11) begin errors++; $display("FAIL w8_latency: got %0d expected 11", lat); end
      checks++; if ({res8, hi8, dbz8} !== {8'h80, 8'h00, 1'b0}) begin errors++; $display("FAIL w8_min_div_m1: got %h_%h_%b expected 80_00_0", res8, hi8, dbz8); end
      run8(2'b01, 8'h80, 8'h80, lat);
      checks++; if ({hi8, res8} !== 16'h4000) begin errors++; $display("FAIL w8_muls_min: got %h expected 4000", {hi8, res8}); end
   endtask

   task automatic test_flush;
      int lat, bb, bad; logic bd; logic seen;
      seen = 1'b0;
      @(posedge clk); #1;
      op32 = 2'b00; a32 = 32'd5; b32 = 32'd6; start32 = 1'b1;
      for (int c = 0; c <= 10; c++) begin
         @(negedge clk);
         if (done32) seen = 1'b1;
         @(posedge clk); #1;
         start32 = 1'b0;
         flush32 = (c == 9);
      end
      checks++; if (busy32 !== 1'b0) begin errors++; $display("FAIL flush_busy: got %b expected 0", busy32); end
      checks++; if ((seen | done32) !== 1'b0) begin errors++; $display("FAIL flush_no_done: got %b expected 0", seen | done32); end
      checks++; if ({hi32, res32} !== 64'h0000001E) begin errors++; $display("FAIL flush_hold: got %h expected 000000000000001e", {hi32, res32}); end
      run32(2'b00, 32'd9, 32'd9, lat, bb, bd);
      checks++; if (lat + 11 !== 46) begin errors++; $display("FAIL flush_restart_latency: got %0d expected 46", lat + 11); end
      checks++; if (res32 !== 32'd81) begin errors++; $display("FAIL flush_restart_result: got %h expected 00000051", res32); end
      @(posedge clk); #1;
      op32 = 2'b00; a32 = 32'd2; b32 = 32'd3; start32 = 1'b1; flush32 = 1'b1;
      @(negedge clk);
      checks++; if (busy32 !== 1'b0) begin errors++; $display("FAIL flush_start_busy: got %b expected 0", busy32); end
      @(posedge clk); #1;
      start32 = 1'b0; flush32 = 1'b0;
      bad = 0;
      repeat (40) begin
         @(negedge clk);
         if (busy32 || done32) bad++;
      end
      checks++; if (bad !== 0) begin errors++; $display("FAIL flush_start_no_op: got %0d active cycles expected 0", bad); end
      checks++; if (res32 !== 32'd81) begin errors++; $display("FAIL flush_start_hold: got %h expected 00000051", res32); end
   endtask

   task automatic test_back_to_back;
      int lat;
      lat = -1;
      @(posedge clk); #1;
      op32 = 2'b00; a32 = 32'h00010000; b32 = 32'h00010000; start32 = 1'b1;
      @(posedge clk); #1;
      start32 = 1'b0; a32 = $urandom; b32 = $urandom;
      repeat (34) @(posedge clk);
      #1;
      op32 = 2'b10; a32 = 32'd1000; b32 = 32'd10; start32 = 1'b1;
      @(negedge clk);
      checks++; if ({done32, busy32} !== 2'b11) begin errors++; $display("FAIL b2b_done_busy: got %b expected 11", {done32, busy32}); end
      checks++; if ({hi32, res32} !== 64'h00000001_00000000) begin errors++; $display("FAIL b2b_first: got %h expected 0000000100000000", {hi32, res32}); end
      for (int c = 1; c < 100; c++) begin
         @(posedge clk); #1;
         start32 = 1'b0; a32 = $urandom; b32 = $urandom;
         @(negedge clk);
         if (done32) begin
            lat = c;
            break;
         end
      end
      checks++; if (lat !== 35) begin errors++; $display("FAIL b2b_latency: got %0d expected 35", lat); end
      checks++; if ({res32, hi32} !== {32'd100, 32'd0}) begin errors++; $display("FAIL b2b_second: got %h_%h expected 00000064_00000000", res32, hi32); end
   endtask

   task automatic test_reset_mid_op;
      int lat, bb, bad; logic bd;
      @(posedge clk); #1;
      op32 = 2'b00; a32 = 32'd3; b32 = 32'd4; start32 = 1'b1;
      @(posedge clk); #1;
      start32 = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      checks++; if ({res32, hi32} !== 64'h0) begin errors++; $display("FAIL rst_mid_results: got %h_%h expected 0", res32, hi32); end
      checks++; if ({busy32, done32, dbz32} !== 3'b000) begin errors++; $display("FAIL rst_mid_flags: got %b expected 000", {busy32, done32, dbz32}); end
      bad = 0;
      repeat (2) begin
         @(negedge clk);
         if (busy32 || done32) bad++;
      end
      rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         if (busy32 || done32) bad++;
      end
      checks++; if (bad !== 0) begin errors++; $display("FAIL rst_mid_quiet: got %0d active cycles expected 0", bad); end
      @(posedge clk); #1;
      run32(2'b00, 32'd7, 32'd6, lat, bb, bd);
      checks++; if (lat !== 35) begin errors++; $display("FAIL rst_restart_latency: got %0d expected 35", lat); end
      checks++; if ({hi32, res32} !== 64'd42) begin errors++; $display("FAIL rst_restart_result: got %h expected 000000000000002a", {hi32, res32}); end
   endtask

   initial begin
      rst_n = 1'b0;
      start32 = 1'b0; flush32 = 1'b0; op32 = 2'b00; a32 = '0; b32 = '0;
      start8 = 1'b0;  flush8 = 1'b0;  op8 = 2'b00;  a8 = '0;  b8 = '0;
      test_reset;
      test_mulu;
      test_divs;
      test_div_by_zero;
      test_muls;
      test_width8;
      test_flush;
      test_back_to_back;
      test_reset_mid_op;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
